// File: rtl/four_bit_divider.sv
// Sequential 8-bit by 4-bit restoring divider, one quotient bit per clock.
// Define DIV_QUOTIENT_OVF_CHECK_EN to flag quotients that do not fit in 4 bits.
module four_bit_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] P,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       div_by_zero,
    output logic       q_ovf
);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] quo_q;    // dividend bits shift out the top, quotient bits shift in
    logic [3:0] rem_q;
    logic [3:0] div_q;
    logic [2:0] cnt_q;
    logic       dz_q;

    logic       accept;
    logic [4:0] trial;
    logic       fits;
    logic [3:0] diff;
    logic [3:0] rem_nxt;

    assign accept = start && (state == IDLE || state == DONE);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // The result is below the divisor, so the low four bits of the difference suffice.
    assign trial   = {rem_q, quo_q[7]};
    assign fits    = (trial >= {1'b0, div_q});
    assign diff    = trial[3:0] - div_q;
    assign rem_nxt = fits ? diff : trial[3:0];

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (B == 4'd0) ? DONE : DIVIDE;
                else
                    state_nxt = IDLE;
            end
            DIVIDE: begin
                if (cnt_q == 3'd7)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            quo_q <= P;
            rem_q <= '0;
            div_q <= B;
            cnt_q <= '0;
            dz_q  <= (B == 4'd0);
        end else if (state == DIVIDE) begin
            quo_q <= {quo_q[6:0], fits};
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Results load on the DONE edge, which is also the edge that raises done,
    // so a back-to-back capture on that same edge cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state == DIVIDE);
            done <= (state == DONE);
            if (state == DONE) begin
                Q           <= dz_q ? 8'hFF : quo_q;
                R           <= dz_q ? 4'h0  : rem_q;
                div_by_zero <= dz_q;
            end
        end
    end

`ifdef DIV_QUOTIENT_OVF_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_ovf <= 1'b0;
        else if (state == DONE)
            q_ovf <= !dz_q && (quo_q[7:4] != 4'd0);
    end
`else
    assign q_ovf = 1'b0;
`endif

endmodule
